sipo_deserializer: RTL and testbench

- Serial-in, parallel-out receiver. It sits directly downstream of the team's 4-bit parallel-load register stage and consumes the serial bit stream that stage produces.
- Shifts bits in under a per-bit valid qualifier and counts them. When a word completes, it transfers the word to a holding output register.
- The holding register is offered to the consumer with a valid/ready handshake.
- Shifting continues while a completed word waits, so one complete word plus one partial word can be in flight.

---
 rtl/sipo_deserializer_pkg.sv | 14 +
 rtl/sipo_shift_core.sv | 47 ++++
 rtl/sipo_deserializer.sv | 62 ++++++
 tb/tb_sipo_deserializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Constants shared by the serial-link stages: bit ordering encodings and
// the default word width used by both the parallel-load source and this receiver.
package sipo_deserializer_pkg;

  localparam int LSB_FIRST_ON  = 1;
  localparam int LSB_FIRST_OFF = 0;
  localparam int DEFAULT_WIDTH = 4;

  // One extra bit so the count can represent WIDTH itself.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for the deserializer; pulses word_done
// combinationally on the edge that samples the final bit of a word.
module sipo_shift_core
  import sipo_deserializer_pkg::*;
#(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter int  LSB_FIRST = LSB_FIRST_ON,
  localparam int CW        = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [CW-1:0]    bit_count,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;

  generate
    if (LSB_FIRST == LSB_FIRST_OFF) begin : g_msb_first
      assign shifted = WIDTH'({sreg, sin});
    end else begin : g_lsb_first
      assign shifted = WIDTH'({sin, sreg} >> 1);
    end
  endgenerate

  // The completed word already contains the bit being sampled this edge.
  assign word      = shifted;
  assign word_done = sin_valid && !clear && (bit_count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sreg      <= '0;
      bit_count <= '0;
    end else if (sin_valid) begin
      sreg      <= shifted;
      bit_count <= (bit_count == LAST) ? '0 : bit_count + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: assembles words from a qualified bit stream
// and offers each one through a holding register with a valid/ready handshake.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter int  LSB_FIRST = LSB_FIRST_ON,
  localparam int CW        = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overflow
);

  logic             word_done;
  logic [WIDTH-1:0] word;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .clear     (clear),
    .bit_count (bit_count),
    .word_done (word_done),
    .word      (word)
  );

  // A completed word may replace the held one only if the slot is empty or
  // is being drained on this same edge; otherwise it is lost and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (word_done && (!pout_valid || pout_ready)) begin
        pout       <= word;
        pout_valid <= 1'b1;
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end

      if (clear) begin
        overflow <= 1'b0;
      end else if (word_done && pout_valid && !pout_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: one LSB-first and one MSB-first instance share stimulus and
// are checked against a bit-list reference model plus an acceptance monitor.
module tb_sipo_deserializer;

  localparam int W  = 4;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst, sin, sin_valid, clear, pout_ready;
  logic [W-1:0]  poutL, poutM;
  logic          pvL, pvM, ovL, ovM;
  logic [CW-1:0] bcL, bcM;

  int errors = 0;
  int checks = 0;

  // Reference model: received bits of the partial word, oldest first.
  bit           bits[$];
  bit           mHold;
  bit           mOvf;
  logic [W-1:0] mWordL, mWordM;
  logic [W-1:0] sbL[$];
  logic [W-1:0] sbM[$];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1)) dutL (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .pout(poutL), .pout_valid(pvL), .pout_ready(pout_ready),
    .bit_count(bcL), .overflow(ovL)
  );

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(0)) dutM (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .pout(poutM), .pout_valid(pvM), .pout_ready(pout_ready),
    .bit_count(bcM), .overflow(ovM)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelStep(input bit r, input bit sv, input bit s, input bit clr, input bit rdy);
    bit           accept = mHold && rdy;
    bit           done   = 1'b0;
    logic [W-1:0] wl     = '0;
    logic [W-1:0] wm     = '0;
    if (r) begin
      bits.delete();
      mHold  = 1'b0;
      mOvf   = 1'b0;
      mWordL = '0;
      mWordM = '0;
      sbL.delete();
      sbM.delete();
      return;
    end
    if (clr) begin
      bits.delete();
      mOvf = 1'b0;
    end else if (sv) begin
      bits.push_back(s);
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wl[i]       = bits[i];
          wm[W-1-i]   = bits[i];
        end
        bits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!mHold || accept) begin
        mWordL = wl;
        mWordM = wm;
        mHold  = 1'b1;
        sbL.push_back(wl);
        sbM.push_back(wm);
      end else begin
        mOvf = 1'b1;
      end
    end else if (accept) begin
      mHold = 1'b0;
    end
  endtask

  task automatic checkOutput();
    check("bit_count_lsb", 32'(bcL), bits.size());
    check("bit_count_msb", 32'(bcM), bits.size());
    check("pout_valid_lsb", 32'(pvL), 32'(mHold));
    check("pout_valid_msb", 32'(pvM), 32'(mHold));
    check("overflow_lsb", 32'(ovL), 32'(mOvf));
    check("overflow_msb", 32'(ovM), 32'(mOvf));
    check("pout_lsb", 32'(poutL), 32'(mWordL));
    check("pout_msb", 32'(poutM), 32'(mWordM));
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled on the next.
  task automatic applyStimulus(input bit r, input bit sv, input bit s, input bit clr, input bit rdy);
    rst        = r;
    sin_valid  = sv;
    sin        = s;
    clear      = clr;
    pout_ready = rdy;
    @(posedge clk);
    modelStep(r, sv, s, clr, rdy);
    #1;
    checkOutput();
  endtask

  task automatic sendWord(input logic [W-1:0] value, input bit rdy);
    for (int i = 0; i < W; i++) applyStimulus(1'b0, 1'b1, value[i], 1'b0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: every accepted word must be the oldest one the model latched.
  always @(negedge clk) begin
    if (!rst && pout_ready) begin
      if (pvL) begin
        if (sbL.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_lsb: got 0x%0h, expected no word offered", poutL);
        end else begin
          check("sb_lsb", 32'(poutL), 32'(sbL.pop_front()));
        end
      end
      if (pvM) begin
        if (sbM.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_msb: got 0x%0h, expected no word offered", poutM);
        end else begin
          check("sb_msb", 32'(poutM), 32'(sbM.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; clear = 1'b0; pout_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_pout", 32'(poutL), 32'h0);
    check("reset_valid", 32'(pvL), 32'h0);

    $display("[TB] consecutive bits 1,0,1,1");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("count_1", 32'(bcL), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("count_3", 32'(bcL), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("word_lsb_1101", 32'(poutL), 32'b1101);
    check("word_msb_1011", 32'(poutM), 32'b1011);
    check("count_wrap", 32'(bcL), 32'd0);
    idle(1, 1'b1);

    $display("[TB] bits with idle gaps");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("gap_msb_1011", 32'(poutM), 32'b1011);
    idle(1, 1'b1);

    $display("[TB] overflow with ready low");
    sendWord(4'hA, 1'b0);
    sendWord(4'h5, 1'b0);
    check("ovf_hold_A", 32'(poutL), 32'hA);
    check("ovf_flag", 32'(ovL), 32'h1);
    idle(1, 1'b1);
    check("ovf_drained", 32'(pvL), 32'h0);

    $display("[TB] replace held word on accepting edge");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sendWord(4'h3, 1'b0);
    for (int i = 0; i < W; i++) applyStimulus(1'b0, 1'b1, i[1:0] != 2'd0 && i != 3, 1'b0, i == W - 1);
    check("replace_6", 32'(poutL), 32'h6);
    check("replace_valid", 32'(pvL), 32'h1);
    check("replace_no_ovf", 32'(ovL), 32'h0);
    idle(1, 1'b1);

    $display("[TB] clear beats a valid bit");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clear_count", 32'(bcL), 32'd0);
    sendWord(4'b0110, 1'b0);
    check("clear_word_0110", 32'(poutL), 32'b0110);
    idle(1, 1'b1);

    $display("[TB] reset mid-word with word held and overflow set");
    sendWord(4'h9, 1'b0);
    sendWord(4'hC, 1'b0);
    sendWord(4'h7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_pout", 32'(poutL), 32'h0);
    check("rst_valid", 32'(pvL), 32'h0);
    check("rst_ovf", 32'(ovL), 32'h0);
    check("rst_count", 32'(bcL), 32'h0);
    sendWord(4'hE, 1'b0);
    check("post_rst_word", 32'(poutL), 32'hE);
    idle(1, 1'b1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(149) == 0, $urandom_range(9) < 7, 1'($urandom),
                    $urandom_range(24) == 0, 1'($urandom));
    end
    idle(3, 1'b1);
    check("sb_lsb_empty", sbL.size(), 32'd0);
    check("sb_msb_empty", sbM.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
